// File: rtl/dld_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dld_pkg
// Brief   : Shared types and defaults for the D-latch datapath front end.
// Revision: 1.0 - initial release
// ============================================================================
package dld_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      QUAL_HI   = 2'd1,
      STABLE_HI = 2'd2,
      QUAL_LO   = 2'd3
   } filt_state_t;

   localparam int DEF_STABLE_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchroniser for a single asynchronous input.
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= d;
         r_s2 <= r_s1;
      end
   end

   assign q = r_s2;

endmodule
`default_nettype wire

// File: rtl/glitch_filter_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : glitch_filter_debouncer
// Brief   : Synchronises a raw line, rejects short pulses, emits edge strobes.
// Revision: 1.0 - initial release
// ============================================================================
module glitch_filter_debouncer
   import dld_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int GCNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d_raw,
   output logic              q_o,
   output logic              rise_o,
   output logic              fall_o,
   output logic              latch_en_o,
   output logic [GCNT_W-1:0] glitch_cnt_o,
   output logic              busy_o
);

   localparam int                   c_cnt_w    = $clog2(STABLE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
   localparam bit                   c_direct   = (STABLE_CYCLES == 1);

   logic                w_s2;
   logic [GCNT_W-1:0]   w_gcnt_next;
   filt_state_t         r_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_q;
   logic                r_rise;
   logic                r_fall;
   logic                r_latch;
   logic [GCNT_W-1:0]   r_gcnt;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d_raw),
      .q     (w_s2)
   );

   // Saturating increment: holds at all-ones until the next reset.
   assign w_gcnt_next = (r_gcnt == {GCNT_W{1'b1}}) ? r_gcnt : r_gcnt + GCNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= STABLE_LO;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_latch <= 1'b0;
         r_gcnt  <= '0;
      end else begin
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_latch <= 1'b0;
         case (r_state)
            STABLE_LO: begin
               if (w_s2) begin
                  if (c_direct) begin
                     r_state <= STABLE_HI;
                     r_q     <= 1'b1;
                     r_rise  <= 1'b1;
                     r_latch <= 1'b1;
                  end else begin
                     r_state <= QUAL_HI;
                     r_cnt   <= c_cnt_w'(1);
                  end
               end
            end
            QUAL_HI: begin
               if (!w_s2) begin
                  r_state <= STABLE_LO;
                  r_cnt   <= '0;
                  r_gcnt  <= w_gcnt_next;
               end else if (r_cnt == c_cnt_last) begin
                  r_state <= STABLE_HI;
                  r_cnt   <= '0;
                  r_q     <= 1'b1;
                  r_rise  <= 1'b1;
                  r_latch <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + c_cnt_w'(1);
               end
            end
            STABLE_HI: begin
               if (!w_s2) begin
                  if (c_direct) begin
                     r_state <= STABLE_LO;
                     r_q     <= 1'b0;
                     r_fall  <= 1'b1;
                     r_latch <= 1'b1;
                  end else begin
                     r_state <= QUAL_LO;
                     r_cnt   <= c_cnt_w'(1);
                  end
               end
            end
            QUAL_LO: begin
               if (w_s2) begin
                  r_state <= STABLE_HI;
                  r_cnt   <= '0;
                  r_gcnt  <= w_gcnt_next;
               end else if (r_cnt == c_cnt_last) begin
                  r_state <= STABLE_LO;
                  r_cnt   <= '0;
                  r_q     <= 1'b0;
                  r_fall  <= 1'b1;
                  r_latch <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + c_cnt_w'(1);
               end
            end
            default: begin
               r_state <= STABLE_LO;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign q_o          = r_q;
   assign rise_o       = r_rise;
   assign fall_o       = r_fall;
   assign latch_en_o   = r_latch;
   assign glitch_cnt_o = r_gcnt;
   assign busy_o       = (r_state == QUAL_HI) || (r_state == QUAL_LO);

endmodule
`default_nettype wire

// File: tb/tb_glitch_filter_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_glitch_filter_debouncer
// Brief   : Directed bench for two filter instances (STABLE_CYCLES 4 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_glitch_filter_debouncer;

   localparam int GW = 8;

   logic          clk;
   logic          rst_n;
   logic          d4, d1;
   logic          q4, rise4, fall4, len4, busy4;
   logic          q1, rise1, fall1, len1, busy1;
   logic [GW-1:0] gc4, gc1;

   int checks   = 0;
   int failures = 0;
   bit busy1_seen = 0;

   glitch_filter_debouncer #(.STABLE_CYCLES(4), .GCNT_W(GW)) dut4 (
      .clk(clk), .rst_n(rst_n), .d_raw(d4), .q_o(q4), .rise_o(rise4),
      .fall_o(fall4), .latch_en_o(len4), .glitch_cnt_o(gc4), .busy_o(busy4));

   glitch_filter_debouncer #(.STABLE_CYCLES(1), .GCNT_W(GW)) dut1 (
      .clk(clk), .rst_n(rst_n), .d_raw(d1), .q_o(q1), .rise_o(rise1),
      .fall_o(fall1), .latch_en_o(len1), .glitch_cnt_o(gc1), .busy_o(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: the filter input is the raw sample from two edges
   // earlier; q flips once the input has disagreed with q for SC straight
   // cycles, and a disagreeing run that ends early counts as one glitch.
   int sc [2] = '{4, 1};
   bit h1 [2], h2 [2];
   bit mq [2], mr [2], mf [2];
   int run [2];
   int mg [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            h1[i] = 0; h2[i] = 0; mq[i] = 0; mr[i] = 0; mf[i] = 0;
            run[i] = 0; mg[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit x;
            x = h2[i];
            h2[i] = h1[i];
            h1[i] = (i == 0) ? d4 : d1;
            mr[i] = 0; mf[i] = 0;
            if (x != mq[i]) begin
               run[i]++;
               if (run[i] == sc[i]) begin
                  mq[i] = x;
                  if (x) mr[i] = 1; else mf[i] = 1;
                  run[i] = 0;
               end
            end else begin
               if (run[i] > 0 && mg[i] < (2**GW - 1)) mg[i]++;
               run[i] = 0;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (busy1) busy1_seen = 1;
      check("dut4_outputs",
            {q4, rise4, fall4, len4, busy4, gc4},
            {mq[0], mr[0], mf[0], mr[0] | mf[0], run[0] > 0, 8'(mg[0])});
      check("dut1_outputs",
            {q1, rise1, fall1, len1, busy1, gc1},
            {mq[1], mr[1], mf[1], mr[1] | mf[1], run[1] > 0, 8'(mg[1])});
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; d4 = 1'b0; d1 = 1'b0;
      // Reset held with inputs toggling.
      for (int i = 0; i < 6; i++) begin
         step(1);
         d4 = ~d4; d1 = ~d1;
      end
      check("reset_q4", q4, 0);
      check("reset_gc4", gc4, 0);
      check("reset_strobes", {rise4, fall4, len4, busy4, q1, busy1}, 0);
      d4 = 1'b0; d1 = 1'b0;
      rst_n = 1'b1;
      step(4);
      check("post_reset_q4", q4, 0);

      // Clean rise: q goes high exactly 6 edges after the input changes.
      d4 = 1'b1;
      step(5);
      check("rise_q_before", q4, 0);
      check("rise_busy_before", busy4, 1);
      step(1);
      check("rise_q_at6", q4, 1);
      check("rise_strobe", {rise4, len4, fall4, busy4}, 4'b1100);
      step(1);
      check("rise_strobe_gone", {rise4, len4}, 0);
      step(3);

      // Short low glitch from STABLE_HI.
      d4 = 1'b0;
      step(2);
      d4 = 1'b1;
      step(8);
      check("glitch_q_held", q4, 1);
      check("glitch_count1", gc4, 1);

      // Transparency pair: fall then rise, 5 cycles apart.
      d4 = 1'b0;
      step(5);
      d4 = 1'b1;
      step(1);
      check("pair_fall", {q4, fall4, rise4, len4}, 4'b0101);
      step(5);
      check("pair_rise", {q4, rise4, fall4, len4}, 4'b1101);
      step(3);

      // Settle low, then reset in the middle of a high qualification.
      d4 = 1'b0;
      step(10);
      d4 = 1'b1;
      step(4);
      check("midq_busy", busy4, 1);
      rst_n = 1'b0;
      d4 = 1'b0;
      #2;
      check("midq_reset_state", {q4, busy4, rise4, len4}, 0);
      check("midq_reset_gc", gc4, 0);
      #1;
      rst_n = 1'b1;
      step(8);
      check("midq_after_q", q4, 0);

      // Saturation: 300 two-cycle high pulses from STABLE_LO.
      for (int i = 0; i < 300; i++) begin
         d4 = 1'b1;
         step(2);
         d4 = 1'b0;
         step(3);
      end
      step(3);
      check("sat_gc", gc4, 255);
      check("sat_q", q4, 0);
      for (int i = 0; i < 5; i++) begin
         d4 = 1'b1;
         step(2);
         d4 = 1'b0;
         step(3);
      end
      step(3);
      check("sat_hold", gc4, 255);

      // STABLE_CYCLES=1: a one-cycle pulse passes straight through.
      d1 = 1'b1;
      step(1);
      d1 = 1'b0;
      step(2);
      check("sc1_rise", {q1, rise1, fall1, len1}, 4'b1101);
      step(1);
      check("sc1_fall", {q1, rise1, fall1, len1}, 4'b0011);
      step(3);
      check("sc1_gc", gc1, 0);
      check("sc1_busy_never", busy1_seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/glitch_filter_debouncer.md
Name: glitch_filter_debouncer

Overview:
- Upstream conditioning stage for the D-latch datapath.
- Takes a raw, asynchronous, possibly glitchy data line and synchronises it into the clk domain.
- Rejects pulses shorter than a programmable number of cycles and presents a clean level, with one-cycle edge strobes, to the latch D/enable inputs.
- Also counts rejected glitches for debug visibility.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised cycles a new level must hold before it is accepted (legal range 1..255).
- GCNT_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- d_raw  input  1  raw asynchronous data line
- q_o  output  1  filtered, debounced level
- rise_o  output  1  one-cycle strobe coincident with q_o going 0->1
- fall_o  output  1  one-cycle strobe coincident with q_o going 1->0
- latch_en_o  output  1  rise_o | fall_o; load strobe for the downstream latch
- glitch_cnt_o  output  GCNT_W  number of rejected pulses, saturating
- busy_o  output  1  high while a candidate level is being qualified

Behaviour:
- Reset (rst_n low, asynchronous): sync flops, q_o, rise_o, fall_o, latch_en_o, busy_o = 0; glitch_cnt_o = 0; counter = 0; FSM = STABLE_LO.
- Release of rst_n takes effect at the next clk edge; no output glitches during reset.
- Synchroniser: two flops, d_raw -> s1 -> s2. Only s2 is used downstream. Fixed 2-cycle latency.
- FSM states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
  - STABLE_LO: if s2=1, go to QUAL_HI and set cnt=1; else stay.
  - QUAL_HI, s2=1 and cnt==STABLE_CYCLES-1: go to STABLE_HI, q_o<=1, rise_o pulses.
  - QUAL_HI, s2=1 otherwise: cnt++.
  - QUAL_HI, s2=0: reject. Return to STABLE_LO, cnt=0, glitch_cnt++ (saturating at 2^GCNT_W-1).
  - STABLE_HI and QUAL_LO: mirror images of the above (fall_o pulses on acceptance).
- STABLE_CYCLES=1: QUAL states are skipped. The FSM goes directly STABLE_x -> STABLE_y in one edge, with a strobe.
- Total latency from a clean d_raw edge to the q_o change: 2 + STABLE_CYCLES clk edges.
- A pulse on s2 lasting < STABLE_CYCLES cycles never reaches q_o.
- A pulse narrower than one clk period may be missed entirely by the synchroniser; this is not counted as a glitch.
- Strobes:
  - rise_o, fall_o and latch_en_o are registered and high for exactly one cycle, in the same cycle q_o changes.
  - rise_o and fall_o are never both high.
- busy_o = 1 exactly in QUAL_HI and QUAL_LO.
- glitch_cnt_o holds at its maximum once saturated; it clears only on reset.
- Counter width is $clog2(STABLE_CYCLES+1); cnt never exceeds STABLE_CYCLES-1.
- Reset mid-qualification aborts immediately: state returns to STABLE_LO, no strobe is emitted, and no glitch is counted.

Decomposition:
- Shared package dld_pkg:
  - typedef enum logic [1:0] filt_state_t {STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO}
  - localparam DEF_STABLE_CYCLES = 4
- One natural sub-module: sync_2ff (two-flop synchroniser, clk, rst_n, d, q), reusable for other async inputs.
- FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with d_raw toggling -> all outputs 0, glitch_cnt_o=0; after release with d_raw=0, outputs stay 0.
- Clean rise (STABLE_CYCLES=4): d_raw 0->1 held 10 cycles -> q_o=1 exactly 6 edges later; rise_o and latch_en_o high for that one cycle only; busy_o high for the 3 preceding cycles.
- Short glitch: from STABLE_HI, d_raw=0 for 2 cycles -> q_o stays 1, no fall_o, glitch_cnt_o=1, busy_o high 2 cycles.
- Transparency pair: d_raw 1->0 held 5 cycles, then 0->1 held 5 cycles -> fall_o pulse then rise_o pulse, 5 cycles apart; q_o tracks with 6-cycle lag.
- Mid-qualification reset: rst_n pulsed low during QUAL_HI (cnt=2) -> state STABLE_LO, q_o=0, no strobe, glitch_cnt_o=0.
- Saturation / edge parameter: 300 two-cycle glitches -> glitch_cnt_o=255 and stays; with STABLE_CYCLES=1, a 1-cycle-wide s2 pulse is accepted (rise_o then fall_o) and busy_o never asserts.
